// File: rtl/chro_packer_if.sv
// Signal bundle between the upstream readout FSM, the chro_packer and the downstream FIFO.
// The slave modport is the packer's view; master is the environment driving it.
interface chro_packer_if #(
  parameter int NCH = 4,
  parameter int DW  = 12
);
  logic              WR_EN;
  logic              CHSEL;
  logic [NCH-1:0]    CH_VALID;
  logic [NCH*DW-1:0] CH_DATA;
  logic              FIFO_FULL;
  logic              FIFO_WR;
  logic [15:0]       FIFO_DATA;
  logic [15:0]       EVT_CNT;
  logic              OVERFLOW;

  modport master (
    output WR_EN, CHSEL, CH_VALID, CH_DATA, FIFO_FULL,
    input  FIFO_WR, FIFO_DATA, EVT_CNT, OVERFLOW
  );

  modport slave (
    input  WR_EN, CHSEL, CH_VALID, CH_DATA, FIFO_FULL,
    output FIFO_WR, FIFO_DATA, EVT_CNT, OVERFLOW
  );
endinterface

// File: rtl/chro_packer.sv
// Packs per-channel ADC samples into 16-bit FIFO words framed by a header and a trailer
// per event; dropped words (FIFO full) raise a sticky OVERFLOW flag.
module chro_packer #(
  parameter int NCH = 4,
  parameter int DW  = 12
) (
  input  logic           CLK,
  input  logic           RST_N,
  chro_packer_if.slave   bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_SELECT,
    S_DATA,
    S_TRAILER
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [NCH-1:0]  r_mask;
  logic [NCH-1:0]  w_mask_next;
  logic [11:0]     r_wcnt;
  logic [11:0]     w_wcnt_next;
  logic [15:0]     r_evt_cnt;
  logic [15:0]     w_evt_next;
  logic            r_fifo_wr;
  logic [15:0]     r_fifo_data;
  logic            r_overflow;

  logic            w_hdr_req;
  logic            w_sel_req;
  logic            w_word_due;
  logic            w_data_due;
  logic            w_trailer;
  logic [15:0]     w_word;
  logic            w_fifo_wr_next;

  logic [DW-1:0]   w_sample [NCH];
  logic [NCH-1:0]  w_pick;
  logic [CW-1:0]   w_chan;
  logic [DW-1:0]   w_chan_sample;

  assign w_hdr_req = bus.WR_EN & ~bus.CHSEL;
  assign w_sel_req = bus.WR_EN &  bus.CHSEL;

  // w_pick is the one-hot lowest set bit of the pending mask.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      localparam logic [NCH-1:0] LOWER = NCH'((64'd1 << gi) - 64'd1);
      assign w_sample[gi] = bus.CH_DATA[gi*DW +: DW];
      assign w_pick[gi]   = r_mask[gi] & ~|(r_mask & LOWER);
    end
  endgenerate

  always_comb begin
    w_chan        = '0;
    w_chan_sample = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_pick[i]) begin
        w_chan        = CW'(i);
        w_chan_sample = w_sample[i];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_mask_next  = r_mask;
    w_wcnt_next  = r_wcnt;
    w_evt_next   = r_evt_cnt;
    w_word_due   = 1'b0;
    w_data_due   = 1'b0;
    w_trailer    = 1'b0;
    w_word       = 16'h0000;

    case (r_state)
      // TRAILER is the cycle the trailer word is on the bus; it accepts a new header like IDLE.
      S_IDLE, S_TRAILER: begin
        w_state_next = S_IDLE;
        if (w_hdr_req) begin
          w_word_due   = 1'b1;
          w_word       = {4'hA, r_evt_cnt[11:0]};
          w_wcnt_next  = 12'h000;
          w_state_next = S_HEADER;
        end
      end
      S_HEADER: begin
        if (w_sel_req) begin
          w_mask_next  = bus.CH_VALID;
          w_state_next = S_SELECT;
        end else if (!w_hdr_req) begin
          w_trailer = 1'b1;
        end
      end
      S_SELECT, S_DATA: begin
        if (w_sel_req) begin
          if (|r_mask) begin
            w_word_due   = 1'b1;
            w_data_due   = 1'b1;
            w_word       = {2'b01, 2'(w_chan), 12'(w_chan_sample)};
            w_mask_next  = r_mask & ~w_pick;
            w_state_next = S_DATA;
          end else begin
            w_mask_next = bus.CH_VALID;
          end
        end else begin
          w_trailer = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_trailer) begin
      w_word_due   = 1'b1;
      w_word       = {4'hF, r_wcnt};
      w_evt_next   = r_evt_cnt + 16'd1;
      w_state_next = S_TRAILER;
    end

    // Only data words that reach the FIFO are counted, saturating at the field maximum.
    if (w_data_due && !bus.FIFO_FULL && (r_wcnt != 12'hFFF)) begin
      w_wcnt_next = r_wcnt + 12'd1;
    end
  end

  assign w_fifo_wr_next = w_word_due & ~bus.FIFO_FULL;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_wcnt      <= 12'h000;
      r_evt_cnt   <= 16'h0000;
      r_fifo_wr   <= 1'b0;
      r_fifo_data <= 16'h0000;
      r_overflow  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_mask     <= w_mask_next;
      r_wcnt     <= w_wcnt_next;
      r_evt_cnt  <= w_evt_next;
      r_fifo_wr  <= w_fifo_wr_next;
      if (w_fifo_wr_next) begin
        r_fifo_data <= w_word;
      end
      r_overflow <= r_overflow | (w_word_due & bus.FIFO_FULL);
    end
  end

  assign bus.FIFO_WR   = r_fifo_wr;
  assign bus.FIFO_DATA = r_fifo_data;
  assign bus.EVT_CNT   = r_evt_cnt;
  assign bus.OVERFLOW  = r_overflow;
endmodule

// File: tb/tb_chro_packer.sv
// Bench for chro_packer: directed spec scenarios plus randomized traffic, checked against
// an event-level reference model (pending-channel queue, word/event counters).
module tb_chro_packer;
  localparam int NCH = 4;
  localparam int DW  = 12;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  chro_packer_if #(.NCH(NCH), .DW(DW)) bus ();
  chro_packer #(.NCH(NCH), .DW(DW)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int txn   = 0;

  // Reference model: 0 = no event open, 1 = header sent, 2 = reading out channels.
  int          m_phase;
  int          m_pend[$];
  int          m_words;
  int          m_events;
  bit          m_ovf;
  bit          exp_wr;
  logic [15:0] exp_data;
  logic [15:0] got_q[$];

  task automatic model_reset();
    m_phase  = 0;
    m_pend.delete();
    m_words  = 0;
    m_events = 0;
    m_ovf    = 0;
  endtask

  task automatic model_load(input bit [3:0] v);
    m_pend.delete();
    for (int i = 0; i < NCH; i++) if (v[i]) m_pend.push_back(i);
  endtask

  task automatic model_eval(input bit we, input bit cs, input bit [3:0] v,
                            input bit [47:0] d, input bit full);
    bit          due = 0;
    bit          is_data = 0;
    bit          trailer = 0;
    int          c;
    logic [15:0] w = 16'h0000;
    case (m_phase)
      0: if (we && !cs) begin
           due = 1; w = 16'hA000 + 16'(m_events % 4096); m_words = 0; m_phase = 1;
         end
      1: if (we && cs) begin
           model_load(v); m_phase = 2;
         end else if (!we) begin
           trailer = 1;
         end
      default: if (we && cs) begin
           if (m_pend.size() > 0) begin
             c = m_pend.pop_front();
             due = 1; is_data = 1;
             w = 16'h4000 + 16'(c * 4096) + 16'(d[c*12 +: 12]);
           end else begin
             model_load(v);
           end
         end else begin
           trailer = 1;
         end
    endcase
    if (trailer) begin
      due = 1; w = 16'hF000 + 16'(m_words);
      m_events = (m_events + 1) % 65536; m_phase = 0;
    end
    if (due && full) m_ovf = 1;
    if (is_data && !full && m_words < 4095) m_words++;
    exp_wr   = due && !full;
    exp_data = w;
  endtask

  // Applies one decoded input for one clock; returns #1 after the edge that registers it.
  task automatic step(input bit we, input bit cs, input bit full);
    bus.WR_EN = we; bus.CHSEL = cs; bus.FIFO_FULL = full;
    model_eval(we, cs, bus.CH_VALID, bus.CH_DATA, full);
    @(posedge CLK); #1;
    txn++;
    if (bus.FIFO_WR === 1'b1) begin
      got_q.push_back(bus.FIFO_DATA);
      $display("txn %0d: in=%b%b full=%b wrote %h evt=%0d", txn, we, cs, full, bus.FIFO_DATA, bus.EVT_CNT);
    end
  endtask

  task automatic do_reset();
    bus.WR_EN = 0; bus.CHSEL = 0; bus.FIFO_FULL = 0;
    @(negedge CLK); RST_N = 0;
    @(posedge CLK); #1; RST_N = 1;
    model_reset();
    got_q.delete();
  endtask

  task automatic test_reset();
    bus.WR_EN = 1; bus.CHSEL = 0; bus.FIFO_FULL = 0;
    bus.CH_VALID = 4'hF; bus.CH_DATA = '1;
    @(posedge CLK); #1;
    n_vec++; if (bus.FIFO_WR !== 1'b0) begin n_err++; $display("FAIL reset_wr: got %b want 0", bus.FIFO_WR); end
    n_vec++; if (bus.FIFO_DATA !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h want 0000", bus.FIFO_DATA); end
    n_vec++; if (bus.EVT_CNT !== 16'h0000) begin n_err++; $display("FAIL reset_evt: got %h want 0000", bus.EVT_CNT); end
    n_vec++; if (bus.OVERFLOW !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.OVERFLOW); end
    do_reset();
  endtask

  task automatic test_basic();
    bit [1:0]    seq [6]  = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    logic [15:0] want [5] = '{16'hA000, 16'h4100, 16'h5101, 16'h7103, 16'hF003};
    do_reset();
    bus.CH_VALID = 4'b1011;
    bus.CH_DATA  = {12'h103, 12'h102, 12'h101, 12'h100};
    foreach (seq[i]) begin
      step(seq[i][1], seq[i][0], 1'b0);
      n_vec++;
      if (bus.FIFO_WR !== exp_wr || (exp_wr && bus.FIFO_DATA !== exp_data)) begin
        n_err++; $display("FAIL basic_step%0d: got wr=%b data=%h want wr=%b data=%h", i, bus.FIFO_WR, bus.FIFO_DATA, exp_wr, exp_data);
      end
    end
    n_vec++;
    if (got_q.size() != 5) begin n_err++; $display("FAIL basic_count: got %0d words want 5", got_q.size()); end
    else foreach (want[i]) if (got_q[i] !== want[i]) begin n_err++; $display("FAIL basic_word%0d: got %h want %h", i, got_q[i], want[i]); end
    n_vec++; if (bus.EVT_CNT !== 16'd1) begin n_err++; $display("FAIL basic_evt: got %0d want 1", bus.EVT_CNT); end
  endtask

  task automatic test_reload();
    bit [1:0]    seq [7]  = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    logic [15:0] want [4] = '{16'hA000, 16'h6102, 16'h6102, 16'hF002};
    do_reset();
    bus.CH_VALID = 4'b0100;
    bus.CH_DATA  = {12'h103, 12'h102, 12'h101, 12'h100};
    foreach (seq[i]) begin
      step(seq[i][1], seq[i][0], 1'b0);
      n_vec++;
      if (bus.FIFO_WR !== exp_wr || (exp_wr && bus.FIFO_DATA !== exp_data)) begin
        n_err++; $display("FAIL reload_step%0d: got wr=%b data=%h want wr=%b data=%h", i, bus.FIFO_WR, bus.FIFO_DATA, exp_wr, exp_data);
      end
    end
    n_vec++;
    if (got_q.size() != 4) begin n_err++; $display("FAIL reload_count: got %0d words want 4", got_q.size()); end
    else foreach (want[i]) if (got_q[i] !== want[i]) begin n_err++; $display("FAIL reload_word%0d: got %h want %h", i, got_q[i], want[i]); end
  endtask

  task automatic test_abort();
    bit [1:0]    seq [6]  = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b01, 2'b11};
    logic [15:0] want [2] = '{16'hA000, 16'hF000};
    do_reset();
    bus.CH_VALID = 4'hF;
    foreach (seq[i]) begin
      step(seq[i][1], seq[i][0], 1'b0);
      n_vec++;
      if (bus.FIFO_WR !== exp_wr || (exp_wr && bus.FIFO_DATA !== exp_data)) begin
        n_err++; $display("FAIL abort_step%0d: got wr=%b data=%h want wr=%b data=%h", i, bus.FIFO_WR, bus.FIFO_DATA, exp_wr, exp_data);
      end
    end
    n_vec++;
    if (got_q.size() != 2) begin n_err++; $display("FAIL abort_count: got %0d words want 2", got_q.size()); end
    else foreach (want[i]) if (got_q[i] !== want[i]) begin n_err++; $display("FAIL abort_word%0d: got %h want %h", i, got_q[i], want[i]); end
    n_vec++; if (bus.EVT_CNT !== 16'd1) begin n_err++; $display("FAIL abort_evt: got %0d want 1", bus.EVT_CNT); end
  endtask

  task automatic test_full_drop();
    bit [1:0]    seq [6]  = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    logic [15:0] want [4] = '{16'hA000, 16'h4100, 16'h7103, 16'hF002};
    do_reset();
    bus.CH_VALID = 4'b1011;
    bus.CH_DATA  = {12'h103, 12'h102, 12'h101, 12'h100};
    foreach (seq[i]) begin
      step(seq[i][1], seq[i][0], i == 3);
      n_vec++;
      if (bus.FIFO_WR !== exp_wr || (exp_wr && bus.FIFO_DATA !== exp_data)) begin
        n_err++; $display("FAIL drop_step%0d: got wr=%b data=%h want wr=%b data=%h", i, bus.FIFO_WR, bus.FIFO_DATA, exp_wr, exp_data);
      end
    end
    n_vec++;
    if (got_q.size() != 4) begin n_err++; $display("FAIL drop_count: got %0d words want 4", got_q.size()); end
    else foreach (want[i]) if (got_q[i] !== want[i]) begin n_err++; $display("FAIL drop_word%0d: got %h want %h", i, got_q[i], want[i]); end
    n_vec++; if (bus.EVT_CNT !== 16'd1) begin n_err++; $display("FAIL drop_evt: got %0d want 1", bus.EVT_CNT); end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0);
    n_vec++; if (bus.OVERFLOW !== 1'b1) begin n_err++; $display("FAIL drop_ovf_sticky: got %b want 1", bus.OVERFLOW); end
    do_reset();
    n_vec++; if (bus.OVERFLOW !== 1'b0) begin n_err++; $display("FAIL drop_ovf_reset: got %b want 0", bus.OVERFLOW); end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      bus.CH_VALID = 4'($urandom);
      bus.CH_DATA  = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      r = $urandom_range(0, 9);
      step(r < 6, r < 4, $urandom_range(0, 7) == 0);
      n_vec++;
      if (bus.FIFO_WR !== exp_wr || (exp_wr && bus.FIFO_DATA !== exp_data)
          || bus.EVT_CNT !== 16'(m_events) || bus.OVERFLOW !== m_ovf) begin
        n_err++;
        $display("FAIL random_cyc%0d: got wr=%b data=%h evt=%h ovf=%b want wr=%b data=%h evt=%h ovf=%b",
                 i, bus.FIFO_WR, bus.FIFO_DATA, bus.EVT_CNT, bus.OVERFLOW, exp_wr, exp_data, 16'(m_events), m_ovf);
      end
    end
  endtask

  task automatic test_wcnt_sat();
    do_reset();
    bus.CH_VALID = 4'hF;
    bus.CH_DATA  = {12'h333, 12'h222, 12'h111, 12'h000};
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5200; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (bus.FIFO_WR !== exp_wr || (exp_wr && bus.FIFO_DATA !== exp_data)) begin
        n_vec++; n_err++;
        $display("FAIL sat_cyc%0d: got wr=%b data=%h want wr=%b data=%h", i, bus.FIFO_WR, bus.FIFO_DATA, exp_wr, exp_data);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    n_vec++;
    if (bus.FIFO_WR !== 1'b1 || bus.FIFO_DATA !== 16'hFFFF) begin
      n_err++; $display("FAIL sat_trailer: got wr=%b data=%h want wr=1 data=ffff", bus.FIFO_WR, bus.FIFO_DATA);
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [15:0] want [2] = '{16'hAFFF, 16'hF000};
    do_reset();
    step(1'b0, 1'b0, 1'b0);
    force dut.r_evt_cnt = 16'hFFFF;
    m_events = 65535;
    step(1'b0, 1'b0, 1'b0);
    release dut.r_evt_cnt;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    n_vec++;
    if (got_q.size() != 2) begin n_err++; $display("FAIL wrap_count: got %0d words want 2", got_q.size()); end
    else foreach (want[i]) if (got_q[i] !== want[i]) begin n_err++; $display("FAIL wrap_word%0d: got %h want %h", i, got_q[i], want[i]); end
    n_vec++; if (bus.EVT_CNT !== 16'h0000) begin n_err++; $display("FAIL wrap_evt: got %h want 0000", bus.EVT_CNT); end
    // Open a new event and reach DATA, then pull reset between clock edges.
    bus.CH_VALID = 4'hF;
    bus.CH_DATA  = {12'h0DD, 12'h0CC, 12'h0BB, 12'h0AA};
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    bus.WR_EN = 0; bus.CHSEL = 0; bus.FIFO_FULL = 0;
    #2 RST_N = 0;
    #1;
    n_vec++;
    if (bus.FIFO_WR !== 1'b0 || bus.FIFO_DATA !== 16'h0000 || bus.EVT_CNT !== 16'h0000 || bus.OVERFLOW !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got wr=%b data=%h evt=%h ovf=%b want all 0", bus.FIFO_WR, bus.FIFO_DATA, bus.EVT_CNT, bus.OVERFLOW);
    end
    @(posedge CLK); #1; RST_N = 1;
    model_reset();
    got_q.delete();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
    n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL reset_no_trailer: got %0d words want 0", got_q.size()); end
    step(1'b1, 1'b0, 1'b0);
    n_vec++;
    if (bus.FIFO_WR !== 1'b1 || bus.FIFO_DATA !== 16'hA000) begin
      n_err++; $display("FAIL post_reset_header: got wr=%b data=%h want wr=1 data=a000", bus.FIFO_WR, bus.FIFO_DATA);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.WR_EN = 0; bus.CHSEL = 0; bus.FIFO_FULL = 0;
    bus.CH_VALID = '0; bus.CH_DATA = '0;
    model_reset();
    test_reset();
    test_basic();
    test_reload();
    test_abort();
    test_full_drop();
    test_random();
    test_wcnt_sat();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
